// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the instruction encoder.
//   - icode constants HALT..POPQ
//   - status codes AOK/HLT/ADR/INS
//   - REG_NONE register id
//   - default instruction memory size
//   - encoder FSM state type
package y86_pkg;

  localparam int MEM_SIZE_DEFAULT = 132;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;

  localparam logic [3:0] STAT_AOK = 4'd0;
  localparam logic [3:0] STAT_HLT = 4'd1;
  localparam logic [3:0] STAT_ADR = 4'd2;
  localparam logic [3:0] STAT_INS = 4'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_STOP = 2'd2
  } enc_state_t;

endpackage

// File: rtl/instr_len_check.sv
// Combinational decode of a Y86-64 instruction's shape.
// Ports:
//   icode, ifun, rA, rB : instruction fields
//   len                 : encoded length in bytes (1, 2, 9 or 10)
//   need_regids         : instruction carries a register-id byte
//   need_valC           : instruction carries an 8-byte constant
//   invalid             : field combination is not a legal encoding
module instr_len_check
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic [3:0] ifun,
  input  logic [3:0] rA,
  input  logic [3:0] rB,
  output logic [3:0] len,
  output logic       need_regids,
  output logic       need_valC,
  output logic       invalid
);

  always_comb begin
    need_regids = 1'b0;
    need_valC   = 1'b0;
    invalid     = 1'b0;
    case (icode)
      I_HALT, I_NOP, I_RET: invalid = (ifun != 4'd0);
      I_RRMOVQ: begin
        need_regids = 1'b1;
        invalid     = (ifun > 4'd6);
      end
      I_IRMOVQ: begin
        need_regids = 1'b1;
        need_valC   = 1'b1;
        invalid     = (ifun != 4'd0) || (rA != REG_NONE);
      end
      I_RMMOVQ, I_MRMOVQ: begin
        need_regids = 1'b1;
        need_valC   = 1'b1;
        invalid     = (ifun != 4'd0);
      end
      I_OPQ: begin
        need_regids = 1'b1;
        invalid     = (ifun > 4'd3);
      end
      I_JXX: begin
        need_valC = 1'b1;
        invalid   = (ifun > 4'd6);
      end
      I_CALL: begin
        need_valC = 1'b1;
        invalid   = (ifun != 4'd0);
      end
      I_PUSHQ, I_POPQ: begin
        need_regids = 1'b1;
        invalid     = (ifun != 4'd0) || (rB != REG_NONE);
      end
      default: invalid = 1'b1;
    endcase
    len = 4'd1 + {3'd0, need_regids} + {need_valC, 3'd0};
  end

endmodule

// File: rtl/instr_encoder.sv
// Y86-64 instruction encoder: accepts one decoded instruction at a time and
// writes its byte encoding into instruction memory, one byte per cycle.
// Ports:
//   clk, reset_n              : clock, synchronous active-low reset
//   in_valid / in_ready       : instruction handshake
//   icode, ifun, rA, rB, valC : instruction fields
//   mem_we, mem_addr, mem_data: byte write port to instruction memory
//   wr_ptr                    : next free byte address (valP of last instruction)
//   stat                      : sticky status (AOK/HLT/ADR/INS)
//
// state | meaning
// IDLE  | waiting for an instruction
// EMIT  | writing bytes of the latched instruction, one per cycle
// STOP  | halted or faulted; held until reset
module instr_encoder
  import y86_pkg::*;
#(
  parameter int MEM_SIZE = MEM_SIZE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] valC,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic [63:0] wr_ptr,
  output logic [3:0]  stat
);

  enc_state_t  r_state, w_state_nxt;
  logic [3:0]  r_icode, r_ifun, r_ra, r_rb;
  logic [63:0] r_valc;
  logic        r_regids;
  logic [3:0]  r_len, r_idx;
  logic [63:0] r_wr_ptr;
  logic [3:0]  r_stat;

  logic [3:0]  w_len;
  logic        w_need_regids, w_need_valc, w_invalid;
  logic [64:0] w_end;
  logic        w_fits, w_accept, w_last;
  logic [2:0]  w_voff;
  logic [7:0]  w_byte;

  instr_len_check u_len_check (
    .icode       (icode),
    .ifun        (ifun),
    .rA          (rA),
    .rB          (rB),
    .len         (w_len),
    .need_regids (w_need_regids),
    .need_valC   (w_need_valc),
    .invalid     (w_invalid)
  );

  // One extra bit keeps wr_ptr+len from wrapping near the top of the address space.
  assign w_end    = {1'b0, r_wr_ptr} + {61'd0, w_len};
  assign w_fits   = (w_end <= 65'(MEM_SIZE));
  assign in_ready = reset_n && (r_state == S_IDLE) && (r_stat == STAT_AOK);
  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_idx == r_len - 4'd1);

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = (w_invalid || !w_fits) ? S_STOP : S_EMIT;
      S_EMIT: if (w_last)   w_state_nxt = (r_icode == I_HALT) ? S_STOP : S_IDLE;
      S_STOP: w_state_nxt = S_STOP;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_icode  <= '0;
      r_ifun   <= '0;
      r_ra     <= '0;
      r_rb     <= '0;
      r_valc   <= '0;
      r_regids <= 1'b0;
      r_len    <= '0;
      r_idx    <= '0;
      r_wr_ptr <= '0;
      r_stat   <= STAT_AOK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_invalid) begin
              r_stat <= STAT_INS;
            end else if (!w_fits) begin
              r_stat <= STAT_ADR;
            end else begin
              r_icode  <= icode;
              r_ifun   <= ifun;
              r_ra     <= rA;
              r_rb     <= rB;
              r_valc   <= w_need_valc ? valC : 64'd0;
              r_regids <= w_need_regids;
              r_len    <= w_len;
              r_idx    <= '0;
            end
          end
        end
        S_EMIT: begin
          if (w_last) begin
            r_idx    <= '0;
            r_wr_ptr <= r_wr_ptr + {60'd0, r_len};
            if (r_icode == I_HALT) r_stat <= STAT_HLT;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Offset of the current byte within valC (only meaningful past the header bytes).
  assign w_voff = 3'(r_idx - (r_regids ? 4'd2 : 4'd1));

  always_comb begin
    if (r_idx == 4'd0)                 w_byte = {r_icode, r_ifun};
    else if (r_regids && r_idx == 4'd1) w_byte = {r_ra, r_rb};
    else                               w_byte = r_valc[{w_voff, 3'b000} +: 8];
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    if (r_state == S_EMIT) begin
      mem_we   = 1'b1;
      mem_addr = r_wr_ptr + {60'd0, r_idx};
      mem_data = w_byte;
    end
  end

  assign wr_ptr = r_wr_ptr;
  assign stat   = r_stat;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  import y86_pkg::*;

  localparam int MEM = 132;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  icode = '0, ifun = '0, rA = '0, rB = '0;
  logic [63:0] valC = '0;
  logic        in_ready, mem_we;
  logic [63:0] mem_addr, wr_ptr;
  logic [7:0]  mem_data;
  logic [3:0]  stat;

  instr_encoder #(.MEM_SIZE(MEM)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .wr_ptr(wr_ptr), .stat(stat)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [63:0] got_a[$], exp_a[$];
  logic [7:0]  got_d[$], exp_d[$];
  logic [63:0] m_ptr = '0;
  logic [3:0]  m_stat = '0;

  always @(negedge clk)
    if (mem_we === 1'b1) begin
      got_a.push_back(mem_addr);
      got_d.push_back(mem_data);
    end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference encoding straight from the Y86-64 format rules; byte i in b[8*i +: 8].
  function automatic void encode(input logic [3:0] ic, fn, ra, rb, input logic [63:0] c,
                                 output int len, output bit bad, output logic [79:0] b);
    bit regs, cw;
    int k;
    regs = ic inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd10, 4'd11};
    cw   = ic inside {4'd3, 4'd4, 4'd5, 4'd7, 4'd8};
    bad  = 0;
    if (ic > 4'd11) bad = 1;
    if (ic inside {4'd0, 4'd1, 4'd9, 4'd3, 4'd4, 4'd5, 4'd8} && fn != 4'd0) bad = 1;
    if ((ic == 4'd2 || ic == 4'd7) && fn > 4'd6) bad = 1;
    if (ic == 4'd6 && fn > 4'd3) bad = 1;
    if (ic == 4'd3 && ra != 4'd15) bad = 1;
    if ((ic == 4'd10 || ic == 4'd11) && (rb != 4'd15 || fn != 4'd0)) bad = 1;
    len = 1 + (regs ? 1 : 0) + (cw ? 8 : 0);
    b = '0;
    b[7:0] = {ic, fn};
    k = 1;
    if (regs) begin
      b[15:8] = {ra, rb};
      k = 2;
    end
    if (cw) for (int i = 0; i < 8; i++) b[8*(k+i) +: 8] = c[8*i +: 8];
  endfunction

  task automatic do_reset(input bit full);
    @(negedge clk);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_mem_we", {63'd0, mem_we}, 64'd0);
    if (full) begin
      check("rst_wr_ptr", wr_ptr, 64'd0);
      check("rst_stat", {60'd0, stat}, 64'd0);
      check("rst_mem_addr", mem_addr, 64'd0);
      check("rst_mem_data", {56'd0, mem_data}, 64'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    if (full) check("rst_in_ready_after", {63'd0, in_ready}, 64'd1);
    got_a.delete(); got_d.delete(); exp_a.delete(); exp_d.delete();
    m_ptr  = '0;
    m_stat = STAT_AOK;
  endtask

  task automatic issue(input logic [3:0] ic, fn, ra, rb, input logic [63:0] c, output time t_acc);
    int w, len;
    bit bad;
    logic [79:0] b;
    w = 0;
    t_acc = 0;
    while (in_ready !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (in_ready !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue_wait: in_ready=%b required 1", in_ready);
      return;
    end
    icode = ic; ifun = fn; rA = ra; rB = rb; valC = c;
    in_valid = 1'b1;
    @(posedge clk);
    t_acc = $time;
    encode(ic, fn, ra, rb, c, len, bad, b);
    if (bad) m_stat = STAT_INS;
    else if (m_ptr + 64'(len) > 64'(MEM)) m_stat = STAT_ADR;
    else begin
      for (int i = 0; i < len; i++) begin
        exp_a.push_back(m_ptr + 64'(i));
        exp_d.push_back(b[8*i +: 8]);
      end
      m_ptr = m_ptr + 64'(len);
      if (ic == I_HALT) m_stat = STAT_HLT;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic settle();
    int w;
    w = 0;
    while (!(mem_we === 1'b0 && (in_ready === 1'b1 || stat !== 4'd0)) && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (w >= 40) begin
      n_chk++;
      n_fail++;
      $display("FAIL settle_timeout: mem_we=%b in_ready=%b stat=%0d", mem_we, in_ready, stat);
    end
  endtask

  task automatic check_state(input string name);
    check({name, "_wr_ptr"}, wr_ptr, m_ptr);
    check({name, "_stat"}, {60'd0, stat}, {60'd0, m_stat});
    check({name, "_in_ready"}, {63'd0, in_ready}, {63'd0, (m_stat == STAT_AOK)});
  endtask

  task automatic compare_writes(input string name);
    int n;
    check({name, "_nwrites"}, 64'(got_a.size()), 64'(exp_a.size()));
    n = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
    for (int i = 0; i < n; i++) begin
      check({name, "_addr"}, got_a[i], exp_a[i]);
      check({name, "_data"}, {56'd0, got_d[i]}, {56'd0, exp_d[i]});
    end
    got_a.delete(); got_d.delete(); exp_a.delete(); exp_d.delete();
  endtask

  typedef struct {
    logic [3:0]  ic, fn, ra, rb;
    logic [63:0] c;
    logic [63:0] exp_ptr;
    logic [3:0]  exp_stat;
  } vec_t;

  initial begin
    vec_t vt[$];
    time t0, t1, t2, t3, t4;
    logic [7:0] r32 [10];
    logic [7:0] r33 [14];
    logic [3:0] ic, fn, ra, rb;
    int r;

    vt.push_back('{4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'd1, 4'd0});
    vt.push_back('{4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'd1, 4'd1});
    vt.push_back('{4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 64'd2, 4'd0});
    vt.push_back('{4'h2, 4'h6, 4'h3, 4'h4, 64'h0, 64'd2, 4'd0});
    vt.push_back('{4'h2, 4'h7, 4'h3, 4'h4, 64'h0, 64'd0, 4'd3});
    vt.push_back('{4'h3, 4'h0, 4'hF, 4'h5, 64'hDEADBEEF_00C0FFEE, 64'd10, 4'd0});
    vt.push_back('{4'h3, 4'h0, 4'h1, 4'h5, 64'h1, 64'd0, 4'd3});
    vt.push_back('{4'h4, 4'h0, 4'h1, 4'h2, 64'h8877665544332211, 64'd10, 4'd0});
    vt.push_back('{4'h5, 4'h1, 4'h1, 4'h2, 64'h0, 64'd0, 4'd3});
    vt.push_back('{4'h6, 4'h3, 4'h7, 4'h8, 64'h0, 64'd2, 4'd0});
    vt.push_back('{4'h6, 4'h4, 4'h7, 4'h8, 64'h0, 64'd0, 4'd3});
    vt.push_back('{4'h7, 4'h6, 4'hF, 4'hF, 64'h0000_0000_0000_1234, 64'd9, 4'd0});
    vt.push_back('{4'h8, 4'h0, 4'hF, 4'hF, 64'hFF00FF00FF00FF00, 64'd9, 4'd0});
    vt.push_back('{4'h8, 4'h1, 4'hF, 4'hF, 64'h0, 64'd0, 4'd3});
    vt.push_back('{4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'd1, 4'd0});
    vt.push_back('{4'hA, 4'h0, 4'h3, 4'hF, 64'h0, 64'd2, 4'd0});
    vt.push_back('{4'hA, 4'h0, 4'hF, 4'h3, 64'h0, 64'd0, 4'd3});
    vt.push_back('{4'hB, 4'h0, 4'h4, 4'hF, 64'h0, 64'd2, 4'd0});
    vt.push_back('{4'hB, 4'h1, 4'h4, 4'hF, 64'h0, 64'd0, 4'd3});
    vt.push_back('{4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'd0, 4'd3});
    vt.push_back('{4'hF, 4'h0, 4'hF, 4'hF, 64'h0, 64'd0, 4'd3});

    do_reset(1);

    foreach (vt[k]) begin
      do_reset(0);
      issue(vt[k].ic, vt[k].fn, vt[k].ra, vt[k].rb, vt[k].c, t0);
      settle();
      check("vec_wr_ptr", wr_ptr, vt[k].exp_ptr);
      check("vec_stat", {60'd0, stat}, {60'd0, vt[k].exp_stat});
      check("vec_in_ready", {63'd0, in_ready}, {63'd0, (vt[k].exp_stat == 4'd0)});
      compare_writes("vec");
    end

    // irmovq $0x0123456789ABCDEF, %rdx
    r32 = '{8'h30, 8'hF2, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    do_reset(0);
    issue(4'h3, 4'h0, 4'hF, 4'h2, 64'h0123456789ABCDEF, t0);
    settle();
    check("irmovq_nwrites", 64'(got_d.size()), 64'd10);
    for (int i = 0; i < 10 && i < got_d.size(); i++) begin
      check("irmovq_addr", got_a[i], 64'(i));
      check("irmovq_byte", {56'd0, got_d[i]}, {56'd0, r32[i]});
    end
    check("irmovq_wr_ptr", wr_ptr, 64'd10);
    check("irmovq_in_ready", {63'd0, in_ready}, 64'd1);
    check("irmovq_stat", {60'd0, stat}, 64'd0);
    compare_writes("irmovq_model");

    // nop; addq %rax,%rcx; ret; jmp 0x40; halt -- back to back
    r33 = '{8'h10, 8'h60, 8'h01, 8'h90, 8'h70, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00};
    do_reset(0);
    issue(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, t0);
    issue(4'h6, 4'h0, 4'h0, 4'h1, 64'h0, t1);
    issue(4'h9, 4'h0, 4'hF, 4'hF, 64'h0, t2);
    issue(4'h7, 4'h0, 4'hF, 4'hF, 64'h40, t3);
    issue(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, t4);
    check("seq_gap_nop", 64'(t1 - t0), 64'd20);
    check("seq_gap_addq", 64'(t2 - t1), 64'd30);
    check("seq_gap_ret", 64'(t3 - t2), 64'd20);
    check("seq_gap_jmp", 64'(t4 - t3), 64'd100);
    settle();
    repeat (10) @(negedge clk);
    check("seq_nwrites", 64'(got_d.size()), 64'd14);
    for (int i = 0; i < 14 && i < got_d.size(); i++) begin
      check("seq_addr", got_a[i], 64'(i));
      check("seq_byte", {56'd0, got_d[i]}, {56'd0, r33[i]});
    end
    check("seq_stat", {60'd0, stat}, 64'd1);
    check("seq_in_ready", {63'd0, in_ready}, 64'd0);
    check("seq_wr_ptr", wr_ptr, 64'd14);
    compare_writes("seq_model");

    // Invalid instructions stop the encoder; later requests are ignored.
    for (int k = 0; k < 2; k++) begin
      do_reset(0);
      if (k == 0) issue(4'h6, 4'h7, 4'h1, 4'h2, 64'h0, t0);
      else        issue(4'hA, 4'h0, 4'hF, 4'h3, 64'h0, t0);
      settle();
      check("ins_stat", {60'd0, stat}, 64'd3);
      check("ins_wr_ptr", wr_ptr, 64'd0);
      icode = 4'h1; ifun = 4'h0; rA = 4'hF; rB = 4'hF;
      in_valid = 1'b1;
      repeat (8) begin
        @(negedge clk);
        check("ins_in_ready_held", {63'd0, in_ready}, 64'd0);
      end
      in_valid = 1'b0;
      check("ins_stat_sticky", {60'd0, stat}, 64'd3);
      check("ins_wr_ptr_after", wr_ptr, 64'd0);
      check("ins_nwrites", 64'(got_a.size()), 64'd0);
      compare_writes("ins_model");
    end

    // in_valid asserted while busy emitting must not start a second instruction.
    do_reset(0);
    issue(4'h3, 4'h0, 4'hF, 4'h1, {$urandom, $urandom}, t0);
    icode = 4'h1; ifun = 4'h0; rA = 4'hF; rB = 4'hF;
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    settle();
    check_state("busy_ignore");
    compare_writes("busy_ignore");

    // Fill to 122, exact fit to 132, then overflow.
    do_reset(0);
    for (int i = 0; i < 12; i++) issue(4'h3, 4'h0, 4'hF, 4'(i), {$urandom, $urandom}, t0);
    issue(4'h6, 4'h1, 4'h2, 4'h3, 64'h0, t0);
    settle();
    check("fill_wr_ptr_122", wr_ptr, 64'd122);
    issue(4'h3, 4'h0, 4'hF, 4'h7, 64'hA5A5_5A5A_0F0F_F0F0, t0);
    settle();
    check("fit_wr_ptr_132", wr_ptr, 64'd132);
    check("fit_stat", {60'd0, stat}, 64'd0);
    issue(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, t0);
    settle();
    repeat (3) @(negedge clk);
    check("adr_stat", {60'd0, stat}, 64'd2);
    check("adr_wr_ptr", wr_ptr, 64'd132);
    check("adr_in_ready", {63'd0, in_ready}, 64'd0);
    compare_writes("fill");

    // Reset while the 4th byte of a call is being written.
    do_reset(0);
    issue(4'h8, 4'h0, 4'hF, 4'hF, 64'h1122334455667788, t0);
    for (int w = 0; w < 20 && !(mem_we === 1'b1 && mem_addr === 64'd3); w++) @(negedge clk);
    check("abort_at_byte3", mem_addr, 64'd3);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_mem_we", {63'd0, mem_we}, 64'd0);
    check("abort_wr_ptr", wr_ptr, 64'd0);
    check("abort_stat", {60'd0, stat}, 64'd0);
    check("abort_in_ready_rst", {63'd0, in_ready}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (4) @(negedge clk);
    while (exp_a.size() > 4) begin
      void'(exp_a.pop_back());
      void'(exp_d.pop_back());
    end
    compare_writes("abort");
    m_ptr = '0;
    m_stat = STAT_AOK;

    // Random instruction streams against the reference model.
    for (int run = 0; run < 6; run++) begin
      do_reset(0);
      for (int n = 0; n < 60 && m_stat == STAT_AOK; n++) begin
        r = int'($urandom_range(0, 99));
        if (r < 3)      ic = 4'h0;
        else if (r < 8) ic = 4'($urandom_range(12, 15));
        else            ic = 4'($urandom_range(1, 11));
        if (ic == 4'h2 || ic == 4'h7) fn = 4'($urandom_range(0, 6));
        else if (ic == 4'h6)          fn = 4'($urandom_range(0, 3));
        else                          fn = 4'h0;
        if ($urandom_range(0, 19) == 0) fn = 4'($urandom_range(0, 15));
        ra = 4'($urandom_range(0, 15));
        rb = 4'($urandom_range(0, 15));
        if (ic == 4'h3 && $urandom_range(0, 9) != 0) ra = 4'hF;
        if ((ic == 4'hA || ic == 4'hB) && $urandom_range(0, 9) != 0) rb = 4'hF;
        issue(ic, fn, ra, rb, {$urandom, $urandom}, t0);
        if ($urandom_range(0, 3) == 0) begin
          settle();
          check_state("rand_mid");
        end
      end
      settle();
      check_state("rand_end");
      compare_writes("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter MEM_SIZE, default 132; size of the instruction memory in bytes.
REQ-002 clk  input  1  rising-edge clock; all state changes occur on the rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 in_valid  input  1  an instruction is presented on icode/ifun/rA/rB/valC.
REQ-005 in_ready  output  1  the encoder accepts an instruction this cycle.
REQ-006 icode, ifun, rA, rB  input  4 each  Y86-64 instruction fields.
REQ-007 valC  input  64  constant word.
REQ-008 mem_we  output  1  byte write strobe to the instruction memory.
REQ-009 mem_addr  output  64  byte address for the write.
REQ-010 mem_data  output  8  byte to write.
REQ-011 wr_ptr  output  64  next free byte address, which equals valP of the last completed instruction.
REQ-012 stat  output  4  status code: 0 AOK, 1 HLT, 2 ADR, 3 INS.

Function
REQ-013 Acceptance SHALL occur on a rising edge where in_valid && in_ready; in_ready SHALL be (state==IDLE && stat==0).
REQ-014 Length SHALL be:
- 1 byte for icode 0, 1, 9.
- 2 bytes for icode 2, 6, 10, 11.
- 9 bytes for icode 7, 8.
- 10 bytes for icode 3, 4, 5.
REQ-015 An instruction is invalid, and SHALL set stat=3 with no write, when any of the following holds:
- icode>11.
- icode 0/1/9/3/4/5/8 with ifun!=0.
- icode 2 or 7 with ifun>6.
- icode 6 with ifun>3.
- icode 3 with rA!=15.
- icode 10/11 with rB!=15 or ifun!=0.
REQ-016 A valid instruction with wr_ptr+len > MEM_SIZE SHALL set stat=2, with no write and no change to wr_ptr.
REQ-017 FSM states SHALL be IDLE, EMIT and STOP, with these transitions:
- IDLE to EMIT on a valid, in-range acceptance; fields and length are latched and byte index idx=0.
- IDLE to STOP when stat becomes 2 or 3.
- EMIT: idx+1 each cycle; on idx==len-1, go to IDLE, or to STOP if icode==0.
- STOP is held until reset.
REQ-018 In EMIT, mem_we SHALL be 1 and mem_addr SHALL be wr_ptr+idx; in all other states mem_we SHALL be 0.
REQ-019 Byte order SHALL be:
- byte0 = {icode,ifun}.
- byte1 = {rA,rB} if the instruction has register ids.
- Then valC little-endian: valC[7:0] first, valC[63:56] last.
REQ-020 Latency: with acceptance at edge T, writes SHALL occur in the cycles following edges T..T+len-1, and in_ready SHALL be 1 again after edge T+len; throughput is one instruction per len+1 cycles.
REQ-021 wr_ptr SHALL increase by len on the edge that leaves EMIT, and SHALL be unchanged at every other time.
REQ-022 After the halt byte is written, stat SHALL become 1 on the same edge that leaves EMIT.
REQ-023 stat SHALL be sticky: once it is nonzero it changes only on reset.
REQ-024 The bounds check SHALL use 65-bit arithmetic so that wr_ptr+len cannot wrap.
REQ-025 An exact fit (wr_ptr+len == MEM_SIZE) SHALL be legal, after which wr_ptr == MEM_SIZE.
REQ-026 in_valid while in_ready=0 SHALL be ignored, with no side effects.

Reset
REQ-027 When reset_n=0 at a rising edge, the block SHALL set state=IDLE, wr_ptr=0, stat=0, idx=0, mem_we=0, mem_addr=0 and mem_data=0.
REQ-028 Reset during EMIT SHALL abort the instruction with no further writes; bytes already written are not undone.
REQ-029 in_ready SHALL be 0 during any cycle in which reset_n=0.

Structure
REQ-030 Shared package y86_pkg SHALL hold:
- icode constants (HALT=0 through POPQ=11).
- stat codes AOK/HLT/ADR/INS.
- The REG_NONE=15 constant.
- The default MEM_SIZE.
REQ-031 The block SHALL contain one combinational sub-module, instr_len_check, with inputs icode/ifun/rA/rB and outputs len[3:0], need_regids, need_valC and invalid.

Verification
REQ-032 From reset, irmovq with rA=F, rB=2, valC=0x0123456789ABCDEF SHALL write 30 F2 EF CD AB 89 67 45 23 01 to addresses 0..9 and leave wr_ptr=10, in_ready=1, stat=0.
REQ-033 From reset, applying nop, addq (rA=0, rB=1), ret, jmp (valC=0x40), then halt back-to-back SHALL write 10 | 60 01 | 90 | 70 40 00 00 00 00 00 00 00 | 00 at addresses 0..13, then stat=1, in_ready=0 and no further writes.
REQ-034 opq with ifun=7, then pushq with rB=3, each from reset, SHALL give stat=3, no mem_we pulse, unchanged wr_ptr, and in_ready held at 0.
REQ-035 With wr_ptr=122, irmovq SHALL be accepted and leave wr_ptr=132; then nop SHALL give stat=2 with no write.
REQ-036 Asserting reset_n=0 at the 4th byte of a call SHALL give mem_we=0 on the next cycle, wr_ptr=0, stat=0, and in_ready=1 once reset_n returns to 1.
